relu_grad_gate: RTL and testbench

Backward-pass counterpart of the layer activation: during the forward pass it records, per neuron, whether the 16-bit pre-activation passed the activation threshold. During the backward pass it reads those flags back in the same neuron order and gates the incoming error gradients. A gradient passes unchanged where the activation was active and is forced to zero where it was clipped. It sits between the forward activation output tap and the error-propagation datapath of one layer.

---
 rtl/nn_pkg.sv | 12 +
 rtl/relu_grad_gate_if.sv | 48 ++++
 rtl/relu_grad_gate.sv | 115 +++++++++++
 tb/tb_relu_grad_gate.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Constants and state type shared by the activation layer's forward and backward blocks.
package nn_pkg;

    localparam int                  NN_WIDTH    = 16;
    localparam logic [NN_WIDTH-1:0] RELU_THRESH = 16'h0100;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } gate_state_t;

endpackage

// File: rtl/relu_grad_gate_if.sv
// Forward-sample, gradient-in and gated-gradient-out handshakes of the ReLU gradient gate.
interface relu_grad_gate_if
    import nn_pkg::*;
#(
    parameter int WIDTH = NN_WIDTH
);

    logic             fwd_valid;
    logic [WIDTH-1:0] fwd_in;
    logic             fwd_ready;

    logic             bwd_valid;
    logic [WIDTH-1:0] bwd_grad;
    logic             bwd_ready;

    logic             out_valid;
    logic [WIDTH-1:0] out_grad;
    logic             out_ready;

    logic             done;

    modport slave (
        input  fwd_valid,
        input  fwd_in,
        output fwd_ready,
        input  bwd_valid,
        input  bwd_grad,
        output bwd_ready,
        output out_valid,
        output out_grad,
        input  out_ready,
        output done
    );

    modport master (
        output fwd_valid,
        output fwd_in,
        input  fwd_ready,
        output bwd_valid,
        output bwd_grad,
        input  bwd_ready,
        input  out_valid,
        input  out_grad,
        output out_ready,
        input  done
    );

endinterface

// File: rtl/relu_grad_gate.sv
// Records per-neuron ReLU activity during the forward pass and uses it to zero
// the error gradients of clipped neurons during the backward pass.
module relu_grad_gate
    import nn_pkg::*;
#(
    parameter int               WIDTH  = NN_WIDTH,
    parameter int               DEPTH  = 8,
    parameter logic [WIDTH-1:0] THRESH = RELU_THRESH
) (
    input  logic            clk,
    input  logic            rst,
    relu_grad_gate_if.slave bus
);

    localparam int               IDX_W    = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(DEPTH);

    gate_state_t      state;
    logic [DEPTH-1:0] mask;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_grad_q;
    logic             done_q;

    logic             fwd_ready_c;
    logic             bwd_ready_c;
    logic             fwd_fire;
    logic             bwd_fire;
    logic             out_fire;
    logic             fwd_active;
    logic [DEPTH-1:0] mask_shift;
    logic             rd_active;

    // Threshold is exclusive: a pre-activation equal to THRESH is clipped.
    function automatic logic is_active(input logic [WIDTH-1:0] pre_act);
        return pre_act > THRESH;
    endfunction

    function automatic logic [WIDTH-1:0] gate_grad(input logic             active,
                                                   input logic [WIDTH-1:0] grad);
        return active ? grad : '0;
    endfunction

    assign fwd_ready_c = (state == FILL);
    assign bwd_ready_c = (state == DRAIN) && (rd_idx < IDX_FULL)
                         && (!out_valid_q || bus.out_ready);

    assign fwd_fire   = bus.fwd_valid && fwd_ready_c;
    assign bwd_fire   = bus.bwd_valid && bwd_ready_c;
    assign out_fire   = out_valid_q && bus.out_ready;
    assign fwd_active = is_active(bus.fwd_in);

    // Shift rather than index so the select stays width-clean for any DEPTH.
    assign mask_shift = mask >> rd_idx;
    assign rd_active  = mask_shift[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            wr_idx      <= '0;
            rd_idx      <= '0;
            mask        <= '0;
            out_valid_q <= 1'b0;
            out_grad_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                FILL: begin
                    if (fwd_fire) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (wr_idx == IDX_W'(i)) begin
                                mask[i] <= fwd_active;
                            end
                        end
                        wr_idx <= wr_idx + IDX_ONE;
                        if (wr_idx == IDX_LAST) begin
                            state  <= DRAIN;
                            rd_idx <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (bwd_fire) begin
                        out_grad_q  <= gate_grad(rd_active, bus.bwd_grad);
                        out_valid_q <= 1'b1;
                        rd_idx      <= rd_idx + IDX_ONE;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                    end
                    // rd_idx == DEPTH excludes a same-cycle gradient, so out_valid clears above.
                    if (out_fire && (rd_idx == IDX_FULL)) begin
                        state  <= FILL;
                        wr_idx <= '0;
                        rd_idx <= '0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign bus.fwd_ready = fwd_ready_c;
    assign bus.bwd_ready = bwd_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_grad  = out_grad_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_relu_grad_gate.sv
// Randomized bench for relu_grad_gate: a flag array plus expected-output queue serve as the reference.
module tb_relu_grad_gate;

    localparam int          DEPTH      = 4;
    localparam logic [15:0] REF_THRESH = 16'h0100;

    typedef logic [15:0] vec_t [DEPTH];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   model_mask [DEPTH];

    always #5 clk = ~clk;

    relu_grad_gate_if #(.WIDTH(16)) bus ();

    relu_grad_gate #(
        .WIDTH (16),
        .DEPTH (DEPTH),
        .THRESH(16'h0100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.fwd_valid = 1'b0;
        bus.fwd_in    = 16'h0;
        bus.bwd_valid = 1'b0;
        bus.bwd_grad  = 16'h0;
        bus.out_ready = 1'b0;
    endtask

    task automatic reset_and_check(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_fwd_ready", 32'(bus.fwd_ready), 32'd1);
        check_eq("rst_bwd_ready", 32'(bus.bwd_ready), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_grad",  32'(bus.out_grad),  32'd0);
        check_eq("rst_done",      32'(bus.done),      32'd0);
    endtask

    // Forward pass: record the expected activity flag of each accepted sample.
    task automatic fill(input vec_t vals, input int valid_pct, input bit bwd_noise);
        int n = 0;
        int cyc = 0;
        while (n < DEPTH && cyc < 300) begin
            @(negedge clk);
            bus.fwd_valid = int'($urandom_range(99)) < valid_pct;
            bus.fwd_in    = bus.fwd_valid ? vals[n] : 16'($urandom);
            bus.bwd_valid = bwd_noise && ($urandom_range(1) == 1);
            bus.bwd_grad  = 16'($urandom);
            bus.out_ready = ($urandom_range(1) == 1);
            #1;
            check_eq("fill_fwd_ready", 32'(bus.fwd_ready), 32'd1);
            check_eq("fill_bwd_ready", 32'(bus.bwd_ready), 32'd0);
            check_eq("fill_out_valid", 32'(bus.out_valid), 32'd0);
            check_eq("fill_done",      32'(bus.done),      32'd0);
            if (bus.fwd_valid && bus.fwd_ready) begin
                model_mask[n] = (vals[n] > REF_THRESH);
                n++;
            end
            cyc++;
        end
        check_eq("fill_timeout", 32'(n), 32'(DEPTH));
    endtask

    // Backward pass: gradients go into the expected queue, gated by the recorded flags.
    task automatic drain(input vec_t grads, input int valid_pct, input int ready_pct,
                         input int stall, input int stop_after, output int cycles);
        logic [15:0] exp_q[$];
        logic [15:0] held = 16'h0;
        logic [15:0] exp_val;
        int          sent = 0;
        int          recv = 0;
        int          cyc = 0;
        int          stall_left = stall;
        bit          hold = 1'b0;
        bit          prev_bwd = 1'b0;
        while (recv < stop_after && cyc < 300) begin
            @(negedge clk);
            bus.fwd_valid = ($urandom_range(1) == 1);
            bus.fwd_in    = 16'($urandom);
            bus.bwd_valid = (sent < DEPTH) && (int'($urandom_range(99)) < valid_pct);
            bus.bwd_grad  = (sent < DEPTH) ? grads[sent] : 16'($urandom);
            if (stall_left > 0 && bus.out_valid) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = int'($urandom_range(99)) < ready_pct;
            end
            #1;
            check_eq("drain_fwd_ready", 32'(bus.fwd_ready), 32'd0);
            check_eq("drain_done",      32'(bus.done),      32'd0);
            if (prev_bwd) check_eq("latency_out_valid", 32'(bus.out_valid), 32'd1);
            if (hold) begin
                check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
                check_eq("bp_out_grad",  32'(bus.out_grad),  32'(held));
            end
            if (bus.out_valid && !bus.out_ready) check_eq("bp_bwd_ready", 32'(bus.bwd_ready), 32'd0);
            hold     = bus.out_valid && !bus.out_ready;
            held     = bus.out_grad;
            prev_bwd = bus.bwd_valid && bus.bwd_ready;
            if (bus.out_valid && bus.out_ready) begin
                check_eq("out_expected", 32'(exp_q.size() != 0), 32'd1);
                exp_val = (exp_q.size() != 0) ? exp_q.pop_front() : 16'h0;
                check_eq($sformatf("out_grad_%0d", recv), 32'(bus.out_grad), 32'(exp_val));
                recv++;
            end
            if (prev_bwd) begin
                exp_q.push_back(model_mask[sent] ? grads[sent] : 16'h0000);
                sent++;
            end
            cyc++;
        end
        check_eq("drain_timeout", 32'(recv), 32'(stop_after));
        cycles = cyc;
    endtask

    task automatic end_of_layer();
        @(negedge clk);
        bus.fwd_valid = 1'b0;
        bus.bwd_valid = 1'b0;
        bus.out_ready = ($urandom_range(1) == 1);
        #1;
        check_eq("eol_done",      32'(bus.done),      32'd1);
        check_eq("eol_fwd_ready", 32'(bus.fwd_ready), 32'd1);
        check_eq("eol_bwd_ready", 32'(bus.bwd_ready), 32'd0);
        check_eq("eol_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #1;
        check_eq("eol_done_pulse", 32'(bus.done), 32'd0);
    endtask

    function automatic logic [15:0] pick_value();
        case ($urandom_range(3))
            0:       return 16'h0100;
            1:       return 16'h0101;
            2:       return 16'($urandom_range(16'h0100));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        vec_t bound_vals;
        vec_t grads;
        vec_t vals;
        int   cyc;

        idle_inputs();
        bound_vals = '{16'h0100, 16'h0101, 16'h0000, 16'hFFFF};
        grads      = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};

        reset_and_check(2);

        // Threshold boundaries at full rate: four outputs on consecutive cycles.
        fill(bound_vals, 100, 1'b0);
        drain(grads, 100, 100, 0, DEPTH, cyc);
        check_eq("throughput_cycles", 32'(cyc), 32'(DEPTH + 1));
        end_of_layer();

        // Backpressure after the first gradient, with stray traffic on the idle side.
        fill(bound_vals, 70, 1'b1);
        drain(grads, 100, 100, 3, DEPTH, cyc);
        end_of_layer();

        // Back-to-back layer with all neurons active.
        for (int i = 0; i < DEPTH; i++) vals[i] = 16'h0200;
        for (int i = 0; i < DEPTH; i++) grads[i] = 16'($urandom);
        fill(vals, 100, 1'b1);
        drain(grads, 80, 80, 0, DEPTH, cyc);
        end_of_layer();

        // Reset mid-drain, then a fully clipped layer.
        for (int i = 0; i < DEPTH; i++) vals[i] = pick_value();
        fill(vals, 100, 1'b0);
        drain(grads, 100, 100, 0, 2, cyc);
        reset_and_check(1);
        for (int i = 0; i < DEPTH; i++) vals[i] = 16'h0000;
        for (int i = 0; i < DEPTH; i++) grads[i] = 16'($urandom) | 16'h0001;
        fill(vals, 100, 1'b0);
        drain(grads, 70, 60, 0, DEPTH, cyc);
        end_of_layer();

        // Random layers mixing boundary values, gaps and stalls.
        for (int l = 0; l < 6; l++) begin
            for (int i = 0; i < DEPTH; i++) vals[i] = pick_value();
            for (int i = 0; i < DEPTH; i++) grads[i] = 16'($urandom);
            fill(vals, 60, 1'b1);
            drain(grads, 60, 50, int'($urandom_range(3)), DEPTH, cyc);
            end_of_layer();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
